// File: rtl/ahb_violation_log_pkg.sv
// Shared definitions for the AHB violation log: register offsets, STATUS layout
// and the logged entry format.
package ahb_violation_log_pkg;

  // Word offsets, i.e. haddr[4:2]
  localparam logic [2:0] OFF_STATUS      = 3'd0;
  localparam logic [2:0] OFF_HEAD_ADDR   = 3'd1;
  localparam logic [2:0] OFF_HEAD_MASTER = 3'd2;
  localparam logic [2:0] OFF_HEAD_INFO   = 3'd3;
  localparam logic [2:0] OFF_POP         = 3'd4;
  localparam logic [2:0] OFF_OVF_CNT     = 3'd5;
  localparam logic [2:0] OFF_CTRL        = 3'd6;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_MSB = 15;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] master;
    logic        write;
  } viol_entry_t;

  localparam int ENTRY_W = $bits(viol_entry_t);

endpackage

// File: rtl/ahb_violation_log_if.sv
// Bus bundle for the violation log: passive monitor tap plus the register slave.
interface ahb_violation_log_if;
  logic        mon_hsel;
  logic [31:0] mon_haddr;
  logic [31:0] mon_hmaster;
  logic        mon_hwrite;
  logic        mon_hready;
  logic        mon_hresp;
  logic        hsel;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        irq;

  modport slave (
    input  mon_hsel, mon_haddr, mon_hmaster, mon_hwrite, mon_hready, mon_hresp,
    input  hsel, haddr, hwrite, hwdata,
    output hrdata, hready, hresp, irq
  );

  modport master (
    output mon_hsel, mon_haddr, mon_hmaster, mon_hwrite, mon_hready, mon_hresp,
    output hsel, haddr, hwrite, hwdata,
    input  hrdata, hready, hresp, irq
  );
endinterface

// File: rtl/ahb_violation_log_viol_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a pop frees the slot for a same-cycle
// push, so push+pop on full is accepted.
module viol_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 65,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         hclk,
  input  logic         hreset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define validity
  always_ff @(posedge hclk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/ahb_violation_log.sv
// Logs AHB ERROR responses seen on the monitor tap into a FIFO that software
// drains through a small zero-wait-state AHB-Lite register slave.
module ahb_violation_log
  import ahb_violation_log_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic                hclk,
  input logic                hreset,
  ahb_violation_log_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  viol_entry_t      pend, head;
  logic             pend_v;
  logic             viol_push, pop_req, fifo_full, fifo_empty;
  logic [AW:0]      fifo_cnt;
  logic             dp_v, dp_write;
  logic [2:0]       dp_off;
  logic             wr_en, ovf_clr, ovf_evt, ovf_flag, irq_en;
  logic [CNT_W-1:0] ovf_cnt;
  logic [31:0]      rdata;
  logic             unused_ok;

  // Remember the data-phase transfer of the monitor until its response ends
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      pend_v <= 1'b0;
      pend   <= '0;
    end else if (bus.mon_hready) begin
      pend_v <= bus.mon_hsel;
      if (bus.mon_hsel) pend <= '{addr: bus.mon_haddr, master: bus.mon_hmaster, write: bus.mon_hwrite};
    end
  end

  // Only the first ERROR cycle (hready low) logs, so each error pushes once
  assign viol_push = pend_v & bus.mon_hresp & ~bus.mon_hready;

  viol_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .hclk  (hclk),
    .hreset(hreset),
    .push  (viol_push),
    .pop   (pop_req),
    .din   (pend),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      dp_v     <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else begin
      dp_v     <= bus.hsel;
      dp_write <= bus.hwrite;
      dp_off   <= bus.haddr[4:2];
    end
  end

  assign wr_en   = dp_v & dp_write;
  assign pop_req = wr_en && (dp_off == OFF_POP);
  assign ovf_clr = wr_en && (dp_off == OFF_OVF_CNT);
  assign ovf_evt = viol_push & fifo_full & ~pop_req;

  // A software clear takes priority over an overflow in the same cycle
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ovf_flag <= 1'b0;
      ovf_cnt  <= '0;
      irq_en   <= 1'b0;
    end else begin
      if (ovf_clr) begin
        ovf_flag <= 1'b0;
        ovf_cnt  <= '0;
      end else if (ovf_evt) begin
        ovf_flag <= 1'b1;
        if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
      if (wr_en && (dp_off == OFF_CTRL)) irq_en <= bus.hwdata[0];
    end
  end

  always_comb begin
    rdata = '0;
    if (dp_v && !dp_write) begin
      case (dp_off)
        OFF_STATUS: begin
          rdata[ST_EMPTY]              = fifo_empty;
          rdata[ST_FULL]               = fifo_full;
          rdata[ST_OVF]                = ovf_flag;
          rdata[ST_CNT_MSB:ST_CNT_LSB] = 8'(fifo_cnt);
        end
        OFF_HEAD_ADDR:   if (!fifo_empty) rdata = head.addr;
        OFF_HEAD_MASTER: if (!fifo_empty) rdata = head.master;
        OFF_HEAD_INFO:   if (!fifo_empty) rdata[0] = head.write;
        OFF_OVF_CNT:     rdata = 32'(ovf_cnt);
        OFF_CTRL:        rdata[0] = irq_en;
        default:         rdata = '0;
      endcase
    end
  end

  assign bus.hrdata = rdata;
  assign bus.hready = 1'b1;
  assign bus.hresp  = 1'b0;
  assign bus.irq    = irq_en & ~fifo_empty;

  assign unused_ok = ^{bus.haddr[7:5], bus.haddr[1:0], bus.hwdata[31:1]};
endmodule

// File: tb/tb_ahb_violation_log.sv
// Directed bench for ahb_violation_log: queue-based model checked every cycle,
// plus literal register reads along the test plan.
module tb_ahb_violation_log;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic hclk   = 1'b0;
  logic hreset = 1'b1;

  ahb_violation_log_if bus();

  ahb_violation_log #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: log is a queue; registers follow the documented map
  typedef struct {
    logic [31:0] addr;
    logic [31:0] master;
    logic        write;
  } ent_t;

  ent_t        q[$];
  ent_t        m_pend;
  bit          m_pend_v, m_ovf, m_irq_en, m_dp_v, m_dp_wr;
  logic [2:0]  m_dp_off;
  int unsigned m_cnt;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      q.delete();
      m_pend_v = 0; m_ovf = 0; m_cnt = 0; m_irq_en = 0;
      m_dp_v = 0; m_dp_wr = 0; m_dp_off = '0;
    end else begin
      bit push, popw, clr;
      push = m_pend_v && bus.mon_hresp && !bus.mon_hready;
      popw = m_dp_v && m_dp_wr && (m_dp_off == 3'd4);
      clr  = m_dp_v && m_dp_wr && (m_dp_off == 3'd5);
      if (m_dp_v && m_dp_wr && (m_dp_off == 3'd6)) m_irq_en = bus.hwdata[0];
      if (popw && q.size() > 0) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(m_pend);
        else if (!clr) begin
          m_ovf = 1;
          if (m_cnt < (2**CNT_W - 1)) m_cnt++;
        end
      end
      if (clr) begin m_ovf = 0; m_cnt = 0; end
      if (bus.mon_hready) begin
        m_pend_v = bus.mon_hsel;
        if (bus.mon_hsel) m_pend = '{bus.mon_haddr, bus.mon_hmaster, bus.mon_hwrite};
      end
      m_dp_v   = bus.hsel;
      m_dp_off = bus.haddr[4:2];
      m_dp_wr  = bus.hwrite;
    end
  end

  function automatic logic [31:0] exp_rdata();
    logic [31:0] r;
    r = '0;
    if (m_dp_v && !m_dp_wr) begin
      case (m_dp_off)
        3'd0: begin
          r[0]    = (q.size() == 0);
          r[1]    = (q.size() == DEPTH);
          r[2]    = m_ovf;
          r[15:8] = 8'(q.size());
        end
        3'd1: if (q.size() > 0) r = q[0].addr;
        3'd2: if (q.size() > 0) r = q[0].master;
        3'd3: if (q.size() > 0) r[0] = q[0].write;
        3'd5: r = m_cnt;
        3'd6: r[0] = m_irq_en;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(negedge hclk) begin
    check("hrdata_model", bus.hrdata, exp_rdata());
    check("irq_model", {31'b0, bus.irq}, {31'b0, m_irq_en && (q.size() > 0)});
    check("hready_hresp", {30'b0, bus.hready, bus.hresp}, 32'h2);
  end

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    @(negedge hclk); bus.hsel = 1; bus.haddr = a; bus.hwrite = 0;
    @(negedge hclk); bus.hsel = 0;
    #1 check(name, bus.hrdata, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge hclk); bus.hsel = 1; bus.haddr = a; bus.hwrite = 1;
    @(negedge hclk); bus.hsel = 0; bus.hwrite = 0; bus.hwdata = d;
  endtask

  // One violation; optionally a register write whose data phase is the first ERROR cycle
  task automatic viol(input logic [31:0] a, input logic [31:0] m, input logic w,
                      input bit with_reg, input logic [7:0] ra, input logic [31:0] rdat);
    @(negedge hclk);
    bus.mon_hsel = 1; bus.mon_haddr = a; bus.mon_hmaster = m; bus.mon_hwrite = w;
    bus.mon_hready = 1; bus.mon_hresp = 0;
    if (with_reg) begin bus.hsel = 1; bus.haddr = ra; bus.hwrite = 1; end
    @(negedge hclk);
    bus.mon_hsel = 0; bus.mon_hready = 0; bus.mon_hresp = 1;
    bus.hsel = 0; bus.hwrite = 0; bus.hwdata = rdat;
    @(negedge hclk); bus.mon_hready = 1; bus.mon_hresp = 1;
    @(negedge hclk); bus.mon_hresp = 0;
  endtask

  // Violations every 2 cycles: next address phase overlaps the second ERROR cycle
  task automatic burst(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      bus.mon_hsel = 1; bus.mon_haddr = base + 32'(4 * i); bus.mon_hmaster = 32'(i);
      bus.mon_hwrite = i[0]; bus.mon_hready = 1; bus.mon_hresp = (i != 0);
      @(negedge hclk);
      bus.mon_hsel = 0; bus.mon_hready = 0; bus.mon_hresp = 1;
    end
    @(negedge hclk); bus.mon_hready = 1; bus.mon_hresp = 1;
    @(negedge hclk); bus.mon_hresp = 0;
  endtask

  initial begin
    bus.mon_hsel = 0; bus.mon_haddr = '0; bus.mon_hmaster = '0; bus.mon_hwrite = 0;
    bus.mon_hready = 1; bus.mon_hresp = 0;
    bus.hsel = 0; bus.haddr = '0; bus.hwrite = 0; bus.hwdata = '0;
    repeat (3) @(negedge hclk);
    hreset = 0;

    // Reset state
    rd(8'h00, 32'h0000_0001, "reset_status");
    rd(8'h04, 32'h0, "reset_head_addr");
    check("reset_irq", {31'b0, bus.irq}, 32'h0);

    // Single violation
    viol(32'h4000_0010, 32'd3, 1'b1, 0, 8'h0, 32'h0);
    rd(8'h00, 32'h0000_0100, "single_status");
    rd(8'h04, 32'h4000_0010, "single_head_addr");
    rd(8'h08, 32'h0000_0003, "single_head_master");
    rd(8'h0C, 32'h0000_0001, "single_head_info");
    check("single_irq_disabled", {31'b0, bus.irq}, 32'h0);
    wr(8'h18, 32'h1);
    @(negedge hclk);
    check("single_irq_enabled", {31'b0, bus.irq}, 32'h1);
    rd(8'h18, 32'h1, "ctrl_read");

    // Pop, then ERROR without a pending transfer
    wr(8'h10, 32'h0);
    @(negedge hclk); bus.mon_hsel = 0; bus.mon_hready = 1; bus.mon_hresp = 1;
    @(negedge hclk); bus.mon_hready = 0;
    @(negedge hclk); bus.mon_hready = 1;
    @(negedge hclk); bus.mon_hresp = 0;
    rd(8'h00, 32'h0000_0001, "no_push_status");

    // Unmapped and write-only offsets
    wr(8'h1C, 32'hFFFF_FFFF);
    rd(8'h1C, 32'h0, "unmapped_read");
    rd(8'h10, 32'h0, "pop_read");

    // Overflow: 10 back-to-back violations into 8 slots
    burst(10, 32'h1000_0000);
    rd(8'h00, 32'h0000_0806, "ovf_status");
    rd(8'h14, 32'h2, "ovf_cnt");
    rd(8'h04, 32'h1000_0000, "ovf_head_addr");

    // Push and pop together while full
    viol(32'h2000_0000, 32'h55, 1'b0, 1, 8'h10, 32'h0);
    rd(8'h00, 32'h0000_0806, "pushpop_status");
    rd(8'h14, 32'h2, "pushpop_ovf_cnt");
    rd(8'h04, 32'h1000_0004, "pushpop_head_addr");

    // Drain in order
    for (int k = 0; k < 8; k++) begin
      logic [31:0] e;
      e = (k < 7) ? 32'h1000_0004 + 32'(4 * k) : 32'h2000_0000;
      rd(8'h04, e, "drain_head_addr");
      wr(8'h10, 32'h0);
    end
    rd(8'h00, 32'h0000_0005, "drained_status");
    rd(8'h04, 32'h0, "drained_head_addr");
    check("drained_irq", {31'b0, bus.irq}, 32'h0);
    wr(8'h10, 32'h0);
    rd(8'h00, 32'h0000_0005, "pop_empty_status");
    wr(8'h14, 32'h0000_FFFF);
    rd(8'h00, 32'h0000_0001, "ovf_clear_status");
    rd(8'h14, 32'h0, "ovf_clear_cnt");

    // Clear in the same cycle as an overflow
    burst(8, 32'h3000_0000);
    viol(32'h3100_0000, 32'd7, 1'b1, 1, 8'h14, 32'h0);
    rd(8'h14, 32'h0, "clear_wins_cnt");
    rd(8'h00, 32'h0000_0802, "clear_wins_status");

    // Reach 5 entries with OVF_CNT=3, then reset mid-cycle
    burst(3, 32'h3200_0000);
    rd(8'h14, 32'h3, "pre_reset_cnt");
    repeat (3) wr(8'h10, 32'h0);
    rd(8'h00, 32'h0000_0504, "pre_reset_status");
    check("pre_reset_irq", {31'b0, bus.irq}, 32'h1);
    @(negedge hclk); #2 hreset = 1;
    @(negedge hclk); hreset = 0;
    check("post_reset_irq", {31'b0, bus.irq}, 32'h0);
    rd(8'h00, 32'h0000_0001, "post_reset_status");
    rd(8'h14, 32'h0, "post_reset_cnt");
    rd(8'h18, 32'h0, "post_reset_ctrl");
    rd(8'h04, 32'h0, "post_reset_head_addr");

    repeat (2) @(negedge hclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_violation_log.md
# ahb_violation_log

Records every access-policy violation the AHB security monitor reports, for software to read out later. It taps the master-side AHB-Lite bus of the monitor passively and detects the two-cycle ERROR response. It captures the offending transfer's address, master ID and direction into a FIFO. Software reads and pops the FIFO through a small AHB-Lite register slave, and an interrupt signals that the log is non-empty.

## Interface
Parameters:
- DEPTH, 8, log entries; power of two, at least 2.
- CNT_W, 16, width of the saturating overflow counter, at most 32.

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  asynchronous, active-high reset.
- mon_hsel  in  1  monitor master-side select.
- mon_haddr  in  32  monitor master-side address.
- mon_hmaster  in  32  monitor master-side master ID.
- mon_hwrite  in  1  monitor master-side write flag.
- mon_hready  in  1  hready_m driven by the monitor.
- mon_hresp  in  1  hresp_m driven by the monitor.
- hsel  in  1  register slave select.
- haddr  in  8  register byte address; bits [4:2] are decoded.
- hwrite  in  1  register write.
- hwdata  in  32  register write data.
- hrdata  out  32  register read data.
- hready  out  1  tied to 1; there are no wait states.
- hresp  out  1  tied to 0.
- irq  out  1  level interrupt.

## Operation
- Tap capture: when mon_hsel and mon_hready are both 1, register mon_haddr, mon_hmaster and mon_hwrite as the pending data-phase record and set pend_v. When mon_hready=1 and mon_hsel=0, clear pend_v.
- Violation detect: the cycle with pend_v=1, mon_hresp=1 and mon_hready=0 is the first ERROR cycle, and it pushes the pending record.
  - The second ERROR cycle (mon_hresp=1, mon_hready=1) never pushes.
  - mon_hresp=1 with pend_v=0 is ignored.
- Entry format: addr[31:0], master[31:0], write[0].
- Register map, selected by the latched haddr[4:2]:
  - 0x00 STATUS, RO: [0] empty, [1] full, [2] overflow (sticky), [15:8] count.
  - 0x04 HEAD_ADDR, RO: address of the oldest entry.
  - 0x08 HEAD_MASTER, RO: master ID of the oldest entry.
  - 0x0C HEAD_INFO, RO: [0] write bit of the oldest entry.
  - 0x10 POP, WO: any write pops one entry.
  - 0x14 OVF_CNT, RW: reads the counter; any write clears both the counter and the overflow flag.
  - 0x18 CTRL, RW: [0] irq_en.
- Unmapped offsets read 0; writes to them are ignored.
- Head registers read 0 while the FIFO is empty.
- Push on full without a same-cycle pop: drop the entry, set overflow, increment OVF_CNT, saturating at 2^CNT_W-1.
- Push and pop in the same cycle while full: both happen; no overflow.
- Pop on empty: ignored.
- A clearing write to OVF_CNT in the same cycle as an overflow: the clear wins, and the counter and flag read 0 afterwards.
- irq = irq_en & ~empty, driven from registered state.

## Timing
- Reset values: hrdata=0, irq=0, pend_v=0, FIFO empty, count=0, overflow=0, OVF_CNT=0, irq_en=0. hready=1 and hresp=0 at all times.
- The register slave is standard AHB-Lite. The address phase (hsel=1) latches haddr[4:2] and hwrite. The data phase follows in the next cycle:
  - hrdata is driven combinationally from the latched offset and the current state.
  - A write takes effect at the end of the data phase, using that cycle's hwdata.
- Push latency: if the first ERROR cycle is cycle N, then count, empty, the head registers and irq reflect the entry from cycle N+1.
- Pop latency: if the POP data phase is cycle M, the next entry is visible from cycle M+1.
- Back-to-back violations every 2 cycles are all logged until the FIFO is full.
- Reset asserted mid-operation clears the FIFO, the counters and pend_v immediately. No entry survives.

## Structure
- Package ahb_violation_log_pkg holds the register offset localparams, the STATUS bit positions, and the entry struct viol_entry_t (addr, master, write).
- One sub-module, viol_fifo: a synchronous FIFO parameterised by DEPTH and entry width.
  - Pointers are log2(DEPTH)+1 bits wide, with wrap detected by the MSB.
  - It provides push, pop, full, empty, count and the head data.
- The top level contains the tap capture, violation detect, register slave, overflow logic and irq.

## Test plan
- Single violation: address phase 0x4000_0010, master 3, write; then ERROR cycles (hresp=1 with hready=0, then hresp=1 with hready=1). Expect STATUS count=1, HEAD_ADDR=0x4000_0010, HEAD_MASTER=3, HEAD_INFO=1, and irq=1 one cycle later once irq_en=1.
- Second ERROR cycle only (mon_hresp=1, mon_hready=1), or hresp with no preceding select: expect no push and count stays 0.
- Overflow: 10 violations with DEPTH=8 and no pops. Expect count=8, overflow=1, OVF_CNT=2, and the head still holding the first entry.
- Full with simultaneous push and pop in the same cycle: expect count to stay 8, OVF_CNT unchanged, and the head to advance to entry 2.
- Drain: 8 POP writes. Expect the entries in order, then empty=1, irq=0 and head reads 0. A 9th POP leaves count=0.
- Reset mid-operation: assert hreset with 5 entries logged and OVF_CNT=3. Expect all registers at their reset values on the next read and irq=0.
